ascon_session_arbiter: RTL and testbench

Shares one Ascon-128 AEAD core between NUM_REQ requesters (sensor, SNN-result and debug channels), one complete session at a time. It arbitrates round-robin, generates unique encryption nonces from a monotonic counter, and pulses the core's start inputs. It muxes the granted requester's input stream into the core, routes the core's output stream and tag/auth result back to that requester, and blocks encryption once the nonce space is exhausted.

---
 rtl/ascon_session_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_ascon_session_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_session_arbiter.sv
// Round-robin session arbiter in front of a single Ascon-128 AEAD core.
// Grants one requester per session, issues counter nonces, and muxes the streams.
module ascon_session_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CTR_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_decrypt,
  input  logic [NUM_REQ*128-1:0] req_nonce,
  input  logic [NUM_REQ*128-1:0] req_tag,
  output logic [NUM_REQ-1:0]     req_grant,
  input  logic [NUM_REQ-1:0]     in_tvalid,
  input  logic [NUM_REQ-1:0]     in_tlast,
  input  logic [NUM_REQ*64-1:0]  in_tdata,
  output logic [NUM_REQ-1:0]     in_tready,
  output logic [NUM_REQ-1:0]     out_tvalid,
  input  logic [NUM_REQ-1:0]     out_tready,
  output logic [63:0]            out_tdata,
  output logic                   out_tlast,
  output logic [NUM_REQ-1:0]     rsp_done,
  output logic [127:0]           rsp_tag,
  output logic [127:0]           rsp_nonce,
  output logic                   rsp_auth_fail,
  output logic                   ctl_busy,
  output logic                   nonce_exhausted,
  output logic                   core_start_encrypt,
  output logic                   core_start_decrypt,
  output logic [127:0]           core_nonce,
  output logic [127:0]           core_tag_in,
  output logic                   core_s_tvalid,
  output logic [63:0]            core_s_tdata,
  output logic                   core_s_tlast,
  input  logic                   core_s_tready,
  input  logic                   core_m_tvalid,
  input  logic [63:0]            core_m_tdata,
  input  logic                   core_m_tlast,
  output logic                   core_m_tready,
  input  logic [127:0]           core_tag_out,
  input  logic                   core_tag_valid,
  input  logic                   core_auth_fail,
  input  logic                   core_busy
);
  localparam int unsigned RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [127-CTR_W:0] NONCE_PREFIX = '0;

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     g_q, g_d, rr_q, rr_d;
  logic              dec_q, dec_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic [127:0]      nonce_q, nonce_d, tagin_q, tagin_d;
  logic [127:0]      rsp_tag_q, rsp_tag_d, rsp_nonce_q, rsp_nonce_d;
  logic              rsp_auth_q, rsp_auth_d;
  logic              tag_seen_q, tag_seen_d, last_seen_q, last_seen_d;

  logic [NUM_REQ-1:0] eligible;
  logic               arb_found;
  logic [RW-1:0]      arb_idx;
  logic               in_open, out_open, s_hs, m_hs;
  logic [63:0]        in_data_a  [NUM_REQ];
  logic [127:0]       req_nonce_a[NUM_REQ];
  logic [127:0]       req_tag_a  [NUM_REQ];

  function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] a, input int unsigned k);
    logic [31:0] s;
    s = (32'(a) + k) % NUM_REQ;
    return s[RW-1:0];
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      in_data_a[k]   = in_tdata[k*64 +: 64];
      req_nonce_a[k] = req_nonce[k*128 +: 128];
      req_tag_a[k]   = req_tag[k*128 +: 128];
    end
  end

  assign nonce_exhausted = &ctr_q;
  assign eligible = req_valid & (req_decrypt | {NUM_REQ{~nonce_exhausted}});

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!arb_found && eligible[wrap_add(rr_q, k)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_add(rr_q, k);
      end
    end
  end

  // Input path only in STREAM; output path stays open until the tlast beat is taken.
  always_comb begin
    in_open       = (state_q == S_STREAM);
    out_open      = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && !last_seen_q;
    core_s_tvalid = in_open && in_tvalid[g_q];
    core_s_tdata  = in_open ? in_data_a[g_q] : '0;
    core_s_tlast  = in_open && in_tlast[g_q];
    in_tready     = '0;
    if (in_open) in_tready[g_q] = core_s_tready;
    out_tvalid    = '0;
    if (out_open) out_tvalid[g_q] = core_m_tvalid;
    core_m_tready = out_open && out_tready[g_q];
    out_tdata     = out_open ? core_m_tdata : '0;
    out_tlast     = out_open && core_m_tlast;
    s_hs          = core_s_tvalid && core_s_tready;
    m_hs          = core_m_tvalid && core_m_tready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      rr_q        <= '0;
      dec_q       <= 1'b0;
      ctr_q       <= '0;
      nonce_q     <= '0;
      tagin_q     <= '0;
      rsp_tag_q   <= '0;
      rsp_nonce_q <= '0;
      rsp_auth_q  <= 1'b0;
      tag_seen_q  <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_q        <= rr_d;
      dec_q       <= dec_d;
      ctr_q       <= ctr_d;
      nonce_q     <= nonce_d;
      tagin_q     <= tagin_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_nonce_q <= rsp_nonce_d;
      rsp_auth_q  <= rsp_auth_d;
      tag_seen_q  <= tag_seen_d;
      last_seen_q <= last_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_d        = rr_q;
    dec_d       = dec_q;
    ctr_d       = ctr_q;
    nonce_d     = nonce_q;
    tagin_d     = tagin_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_nonce_d = rsp_nonce_q;
    rsp_auth_d  = rsp_auth_q;
    tag_seen_d  = tag_seen_q;
    last_seen_d = last_seen_q;
    // Tag and final output beat may land in either order, or together.
    if ((state_q == S_STREAM || state_q == S_DRAIN) && core_tag_valid && !tag_seen_q) begin
      tag_seen_d  = 1'b1;
      rsp_tag_d   = core_tag_out;
      rsp_auth_d  = dec_q && core_auth_fail;
      rsp_nonce_d = nonce_q;
    end
    if (m_hs && core_m_tlast) last_seen_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (arb_found && !core_busy) begin
          g_d     = arb_idx;
          dec_d   = req_decrypt[arb_idx];
          nonce_d = req_decrypt[arb_idx] ? req_nonce_a[arb_idx] : {NONCE_PREFIX, ctr_q};
          tagin_d = req_decrypt[arb_idx] ? req_tag_a[arb_idx] : '0;
          rr_d    = wrap_add(arb_idx, 1);
          if (!req_decrypt[arb_idx]) ctr_d = ctr_q + CTR_W'(1);
          state_d = S_START;
        end
      end
      S_START:  state_d = S_STREAM;
      S_STREAM: if (s_hs && core_s_tlast) state_d = S_DRAIN;
      S_DRAIN:  if (tag_seen_d && last_seen_d) state_d = S_DONE;
      S_DONE: begin
        tag_seen_d  = 1'b0;
        last_seen_d = 1'b0;
        state_d     = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_grant = '0;
    if (rst_n && state_q == S_IDLE && arb_found && !core_busy) req_grant[arb_idx] = 1'b1;
    core_start_encrypt = (state_q == S_START) && !dec_q;
    core_start_decrypt = (state_q == S_START) && dec_q;
    rsp_done = '0;
    if (state_q == S_DONE) rsp_done[g_q] = 1'b1;
    ctl_busy = (state_q != S_IDLE);
  end

  assign core_nonce    = nonce_q;
  assign core_tag_in   = tagin_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_nonce     = rsp_nonce_q;
  assign rsp_auth_fail = rsp_auth_q;
endmodule

// File: tb/tb_ascon_session_arbiter.sv
// Scoreboard bench for ascon_session_arbiter with a behavioural stand-in core.
module tb_ascon_session_arbiter;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam logic [63:0] MASK = 64'hA5A5_5A5A_F00F_0FF0;

  logic clk, rst_n;
  logic [N-1:0] req_valid, req_decrypt, req_grant;
  logic [N*128-1:0] req_nonce, req_tag;
  logic [N-1:0] in_tvalid, in_tlast, in_tready, out_tvalid, out_tready, rsp_done;
  logic [N*64-1:0] in_tdata;
  logic [63:0] out_tdata, core_s_tdata, core_m_tdata;
  logic out_tlast, rsp_auth_fail, ctl_busy, nonce_exhausted;
  logic [127:0] rsp_tag, rsp_nonce, core_nonce, core_tag_in, core_tag_out;
  logic core_start_encrypt, core_start_decrypt, core_s_tvalid, core_s_tlast, core_s_tready;
  logic core_m_tvalid, core_m_tlast, core_m_tready, core_tag_valid, core_auth_fail, core_busy;

  ascon_session_arbiter #(.NUM_REQ(N), .CTR_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_decrypt(req_decrypt),
    .req_nonce(req_nonce), .req_tag(req_tag), .req_grant(req_grant),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tdata(in_tdata), .in_tready(in_tready),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
    .rsp_done(rsp_done), .rsp_tag(rsp_tag), .rsp_nonce(rsp_nonce), .rsp_auth_fail(rsp_auth_fail),
    .ctl_busy(ctl_busy), .nonce_exhausted(nonce_exhausted),
    .core_start_encrypt(core_start_encrypt), .core_start_decrypt(core_start_decrypt),
    .core_nonce(core_nonce), .core_tag_in(core_tag_in),
    .core_s_tvalid(core_s_tvalid), .core_s_tdata(core_s_tdata), .core_s_tlast(core_s_tlast),
    .core_s_tready(core_s_tready), .core_m_tvalid(core_m_tvalid), .core_m_tdata(core_m_tdata),
    .core_m_tlast(core_m_tlast), .core_m_tready(core_m_tready), .core_tag_out(core_tag_out),
    .core_tag_valid(core_tag_valid), .core_auth_fail(core_auth_fail), .core_busy(core_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] model_tag(input logic [127:0] n, input logic [63:0] a);
    return {n[127:64] ^ n[63:0] ^ a, a ^ 64'h0123_4567_89AB_CDEF};
  endfunction

  function automatic logic [63:0] msg_acc(input logic [63:0] base, input int len);
    logic [63:0] a;
    a = '0;
    for (int k = 0; k < len; k++) a = a ^ (base + 64'(k));
    return a;
  endfunction

  // Stand-in core: echoes input ^ MASK, tag two cycles after the last input beat.
  logic cbusy, cdec, cin_done;
  logic [127:0] cnonce, ctagin;
  logic [63:0] acc;
  int cdly;
  logic [64:0] cfifo [8];
  logic [2:0] wp, rp;
  logic [3:0] cnt;
  logic c_push, c_pop;
  assign core_s_tready = cbusy && !cin_done && (cnt < 4'd6);
  assign core_m_tvalid = (cnt != 4'd0);
  assign {core_m_tlast, core_m_tdata} = cfifo[rp];
  assign core_busy = cbusy;
  assign c_push = core_s_tvalid && core_s_tready;
  assign c_pop  = core_m_tvalid && core_m_tready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cbusy <= 1'b0; cdec <= 1'b0; cin_done <= 1'b0; cnonce <= '0; ctagin <= '0; acc <= '0;
      cdly <= 0; wp <= '0; rp <= '0; cnt <= '0;
      core_tag_valid <= 1'b0; core_tag_out <= '0; core_auth_fail <= 1'b0;
    end else begin
      core_tag_valid <= 1'b0;
      if (cdly != 0) begin
        cdly <= cdly - 1;
        if (cdly == 1) begin
          core_tag_valid <= 1'b1;
          core_tag_out   <= model_tag(cnonce, acc);
          core_auth_fail <= cdec && (ctagin != model_tag(cnonce, acc));
          cbusy          <= 1'b0;
        end
      end
      if (core_start_encrypt || core_start_decrypt) begin
        cbusy <= 1'b1; cdec <= core_start_decrypt; cnonce <= core_nonce;
        ctagin <= core_tag_in; acc <= '0; cin_done <= 1'b0;
      end
      if (c_push) begin
        cfifo[wp] <= {core_s_tlast, core_s_tdata ^ MASK};
        wp  <= wp + 3'd1;
        acc <= acc ^ core_s_tdata;
        if (core_s_tlast) begin cin_done <= 1'b1; cdly <= 2; end
      end
      if (c_pop) rp <= rp + 3'd1;
      cnt <= cnt + 4'(c_push) - 4'(c_pop);
    end
  end

  typedef struct { int idx; logic [63:0] data; logic last; } beat_t;
  typedef struct { int idx; logic [127:0] tag; logic [127:0] nonce; logic auth; } done_t;
  typedef struct { logic dec; logic [127:0] nonce; } start_t;
  int     grant_q[$];
  start_t start_q[$];
  beat_t  beat_q[$];
  done_t  done_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, grant_cyc = 0, grant_cnt = 0, start_cnt = 0, done_cnt = 0, tag_cnt = 0, in_last_cnt = 0;
  int ctr_m = 0, exp_done = 0;
  logic [63:0] msg_base [N];
  int msg_len [N];
  logic [N-1:0] m_hs_vec;
  assign m_hs_vec = out_tvalid & out_tready;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_tag_valid) tag_cnt++;
      if (req_grant != '0) begin
        grant_cnt++;
        grant_cyc = cyc;
        if (grant_q.size() == 0) fail("unexpected_grant");
        else begin
          chk("grant", 128'(req_grant), 128'(1) << grant_q[0]);
          void'(grant_q.pop_front());
        end
      end
      if (core_start_encrypt || core_start_decrypt) begin
        start_cnt++;
        chk("start_latency", 128'(cyc - grant_cyc), 128'(1));
        if (start_q.size() == 0) fail("unexpected_start");
        else begin
          chk("start_op", 128'({core_start_encrypt, core_start_decrypt}),
              start_q[0].dec ? 128'(1) : 128'(2));
          chk("core_nonce", core_nonce, start_q[0].nonce);
          void'(start_q.pop_front());
        end
      end
      if (m_hs_vec != '0) begin
        if (beat_q.size() == 0) fail("unexpected_out_beat");
        else begin
          chk("out_req", 128'(m_hs_vec), 128'(1) << beat_q[0].idx);
          chk("out_data", 128'(out_tdata), 128'(beat_q[0].data));
          chk("out_last", 128'(out_tlast), 128'(beat_q[0].last));
          void'(beat_q.pop_front());
        end
      end
      if (rsp_done != '0) begin
        done_cnt++;
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          chk("done_req", 128'(rsp_done), 128'(1) << done_q[0].idx);
          chk("rsp_tag", rsp_tag, done_q[0].tag);
          chk("rsp_nonce", rsp_nonce, done_q[0].nonce);
          chk("rsp_auth_fail", 128'(rsp_auth_fail), 128'(done_q[0].auth));
          void'(done_q.pop_front());
        end
      end
    end
  end

  // Requester-side stream driver: drops req_valid after grant and feeds the granted stream.
  int drv_active = -1, drv_beat = 0;
  logic [N-1:0] drv_gr;
  logic drv_hs;
  initial begin
    forever begin
      @(posedge clk);
      drv_gr = req_grant;
      drv_hs = (drv_active >= 0) && in_tvalid[drv_active] && in_tready[drv_active];
      #1;
      if (!rst_n) begin
        drv_active = -1; in_tvalid = '0; in_tlast = '0;
      end else begin
        if (drv_hs) begin
          if (drv_beat == msg_len[drv_active] - 1) begin
            in_last_cnt++;
            in_tvalid[drv_active] = 1'b0;
            in_tlast[drv_active]  = 1'b0;
            drv_active = -1;
          end else drv_beat++;
        end
        for (int i = 0; i < N; i++)
          if (drv_gr[i]) begin req_valid[i] = 1'b0; drv_active = i; drv_beat = 0; end
        if (drv_active >= 0) begin
          in_tvalid[drv_active] = 1'b1;
          in_tdata[drv_active*64 +: 64] = msg_base[drv_active] + 64'(drv_beat);
          in_tlast[drv_active] = (drv_beat == msg_len[drv_active] - 1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic setup_req(input int idx, input logic dec, input logic [127:0] n,
                           input logic [127:0] t, input int len, input logic [63:0] base);
    msg_len[idx] = len; msg_base[idx] = base; req_decrypt[idx] = dec;
    req_nonce[idx*128 +: 128] = n; req_tag[idx*128 +: 128] = t;
  endtask

  task automatic expect_session(input int idx, input logic dec, input logic [127:0] dn, input logic auth);
    logic [127:0] nonce;
    nonce = dec ? dn : 128'(ctr_m);
    if (!dec) ctr_m++;
    grant_q.push_back(idx);
    start_q.push_back('{dec: dec, nonce: nonce});
    for (int k = 0; k < msg_len[idx]; k++)
      beat_q.push_back('{idx: idx, data: (msg_base[idx] + 64'(k)) ^ MASK, last: (k == msg_len[idx] - 1)});
    done_q.push_back('{idx: idx, tag: model_tag(nonce, msg_acc(msg_base[idx], msg_len[idx])),
                       nonce: nonce, auth: auth});
    exp_done++;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (done_cnt < exp_done && c < budget) begin tick(1); c++; end
    if (done_cnt < exp_done) fail("timeout_waiting_done");
    tick(2);
  endtask

  logic [127:0] dn, good_tag;
  int d0, t0, l0, s0, g0, c;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_decrypt = '0; req_nonce = '0; req_tag = '0;
    in_tvalid = '0; in_tlast = '0; in_tdata = '0; out_tready = '1;
    for (int i = 0; i < N; i++) begin msg_base[i] = '0; msg_len[i] = 1; end
    tick(3);
    chk("rst_busy", 128'(ctl_busy), 0);
    chk("rst_exhausted", 128'(nonce_exhausted), 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_nonce", rsp_nonce, 0);
    chk("rst_auth", 128'(rsp_auth_fail), 0);
    chk("rst_core_nonce", core_nonce, 0);
    rst_n = 1'b1;
    tick(2);

    // single encrypt on requester 1, two beats
    setup_req(1, 1'b0, '0, '0, 2, 64'h0000_1000_0000_0000);
    expect_session(1, 1'b0, '0, 1'b0);
    req_valid[1] = 1'b1;
    wait_done(200);
    chk("grant_count_single", 128'(grant_cnt), 1);

    // reset in idle, then all four at once: order 0,1,2,3
    rst_n = 1'b0; tick(2); rst_n = 1'b1; ctr_m = 0; tick(1);
    for (int i = 0; i < N; i++) setup_req(i, 1'b0, '0, '0, 1 + (i % 2), 64'h2000 + 64'(i * 256));
    for (int i = 0; i < N; i++) expect_session(i, 1'b0, '0, 1'b0);
    req_valid = '1;
    wait_done(600);

    // pointer back at 0: simultaneous 2 and 0 serve 0 first
    setup_req(2, 1'b0, '0, '0, 2, 64'h2200);
    setup_req(0, 1'b0, '0, '0, 1, 64'h2400);
    expect_session(0, 1'b0, '0, 1'b0);
    expect_session(2, 1'b0, '0, 1'b0);
    req_valid[2] = 1'b1; req_valid[0] = 1'b1;
    wait_done(400);

    // decrypt on requester 3: wrong tag then correct tag
    dn = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    good_tag = model_tag(dn, msg_acc(64'h3000, 2));
    setup_req(3, 1'b1, dn, good_tag ^ 128'h1, 2, 64'h3000);
    expect_session(3, 1'b1, dn, 1'b1);
    req_valid[3] = 1'b1;
    wait_done(200);
    setup_req(3, 1'b1, dn, good_tag, 2, 64'h3000);
    expect_session(3, 1'b1, dn, 1'b0);
    req_valid[3] = 1'b1;
    wait_done(200);

    // output back-pressure: tag arrives first, done waits for the tlast handshake
    out_tready[2] = 1'b0;
    setup_req(2, 1'b0, '0, '0, 3, 64'h4000);
    expect_session(2, 1'b0, '0, 1'b0);
    d0 = done_cnt; t0 = tag_cnt; l0 = in_last_cnt;
    req_valid[2] = 1'b1;
    c = 0;
    while (in_last_cnt == l0 && c < 200) begin tick(1); c++; end
    if (in_last_cnt == l0) fail("timeout_waiting_last_input");
    tick(30);
    chk("no_early_done", 128'(done_cnt), 128'(d0));
    chk("tag_before_output", 128'(tag_cnt > t0), 1);
    chk("busy_while_drain", 128'(ctl_busy), 1);
    out_tready[2] = 1'b1;
    wait_done(200);

    // exhaust the 4-bit counter: 8 more encrypts reach 15
    for (int k = 0; k < 8; k++) begin
      if (k == 7) chk("not_yet_exhausted", 128'(nonce_exhausted), 0);
      setup_req(k % N, 1'b0, '0, '0, 1, 64'h5000 + 64'(k));
      expect_session(k % N, 1'b0, '0, 1'b0);
      req_valid[k % N] = 1'b1;
      wait_done(200);
    end
    chk("exhausted", 128'(nonce_exhausted), 1);

    // encrypt on 3 blocked, concurrent decrypt on 1 still granted
    setup_req(3, 1'b0, '0, '0, 1, 64'h6000);
    setup_req(1, 1'b1, dn, '0, 1, 64'h6100);
    expect_session(1, 1'b1, dn, 1'b1);
    req_valid[3] = 1'b1; req_valid[1] = 1'b1;
    wait_done(200);
    g0 = grant_cnt;
    tick(20);
    chk("no_encrypt_grant_exhausted", 128'(grant_cnt), 128'(g0));
    req_valid[3] = 1'b0;

    // reset in the middle of STREAM
    out_tready[0] = 1'b0;
    setup_req(0, 1'b1, dn, '0, 4, 64'h7000);
    grant_q.push_back(0);
    start_q.push_back('{dec: 1'b1, nonce: dn});
    s0 = start_cnt;
    req_valid[0] = 1'b1;
    c = 0;
    while (start_cnt == s0 && c < 100) begin tick(1); c++; end
    if (start_cnt == s0) fail("timeout_waiting_start");
    tick(1);
    chk("busy_in_stream", 128'(ctl_busy), 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(ctl_busy), 0);
    chk("mid_rst_in_tready", 128'(in_tready), 0);
    chk("mid_rst_out_tvalid", 128'(out_tvalid), 0);
    chk("mid_rst_core_s", 128'({core_s_tvalid, core_m_tready, core_start_encrypt, core_start_decrypt}), 0);
    chk("mid_rst_core_nonce", core_nonce, 0);
    chk("mid_rst_core_tag_in", core_tag_in, 0);
    chk("mid_rst_rsp", rsp_tag | rsp_nonce | 128'(rsp_auth_fail), 0);
    chk("mid_rst_exhausted", 128'(nonce_exhausted), 0);
    chk("mid_rst_done", 128'(rsp_done), 0);
    tick(2);
    rst_n = 1'b1; out_tready = '1; ctr_m = 0;
    tick(10);
    chk("no_done_after_abort", 128'(done_cnt), 128'(d0));

    // counter restarts at zero after reset
    setup_req(2, 1'b0, '0, '0, 2, 64'h8000);
    expect_session(2, 1'b0, '0, 1'b0);
    req_valid[2] = 1'b1;
    wait_done(200);

    chk("queues_empty", 128'(grant_q.size() + start_q.size() + beat_q.size() + done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end
endmodule
